bf_stream_io: RTL and testbench

- Parametrised I/O endpoint for the BF cpu data port. It replaces the ad-hoc incrementing-byte stimulus with a synthesizable block.
- Input path: feeds cpu data_in / data_available / data_read, either from a host-loaded FIFO or from an internal incrementing generator.
- Output path: captures cpu data_out / data_out_en into a FIFO that the host drains with a valid/ready handshake.
- Sits between the cpu and a host (UART bridge or bench).

---
 rtl/bf_stream_io.sv | 163 ++++++++++++++++
 tb/tb_bf_stream_io.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_stream_io.sv
// Data-port I/O endpoint for the BF cpu: host-fed input FIFO or incrementing
// generator on the input side, host-drained capture FIFO on the output side.

module bf_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  // Callers qualify push/pop: push only when not full (or popping), pop only when not empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign level = cnt;
  assign head  = empty ? '0 : mem[rd_ptr];
endmodule

module bf_stream_io #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int START_DELAY = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     gen_mode,
  input  logic [DATA_WIDTH-1:0]    gen_seed,
  output logic [DATA_WIDTH-1:0]    cpu_data_in,
  output logic                     cpu_data_available,
  input  logic                     cpu_data_read,
  input  logic [DATA_WIDTH-1:0]    cpu_data_out,
  input  logic                     cpu_data_out_en,
  input  logic [DATA_WIDTH-1:0]    host_in_data,
  input  logic                     host_in_valid,
  output logic                     host_in_ready,
  output logic [DATA_WIDTH-1:0]    host_out_data,
  output logic                     host_out_valid,
  input  logic                     host_out_ready,
  output logic [$clog2(DEPTH):0]   in_level,
  output logic                     out_overflow
);
  localparam int CW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

  logic [CW-1:0]         dly_cnt;
  logic                  dly_done;
  logic [DATA_WIDTH-1:0] gen_q;

  logic [DATA_WIDTH-1:0] in_head;
  logic                  in_full;
  logic                  in_empty;
  logic                  in_push;
  logic                  in_pop;

  logic [DATA_WIDTH-1:0] out_head;
  logic [$clog2(DEPTH):0] out_level;
  logic                  out_full;
  logic                  out_empty;
  logic                  out_push;
  logic                  out_pop;
  logic                  cpu_take;

  assign dly_done = (dly_cnt == CW'(START_DELAY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_cnt <= '0;
    end else if (!dly_done) begin
      dly_cnt <= dly_cnt + 1'b1;
    end
  end

  assign cpu_data_available = dly_done & (gen_mode | ~in_empty);
  assign cpu_data_in        = gen_mode ? gen_q : in_head;
  assign cpu_take           = cpu_data_read & cpu_data_available;

  // Seed is captured into the generator while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q <= gen_seed;
    end else if (gen_mode && cpu_take) begin
      gen_q <= gen_q + 1'b1;
    end
  end

  // Input ready is independent of a same-cycle pop so a full FIFO refuses pushes.
  assign host_in_ready = ~in_full;
  assign in_push       = host_in_valid & host_in_ready;
  assign in_pop        = ~gen_mode & cpu_take;

  bf_stream_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_push),
    .wdata (host_in_data),
    .pop   (in_pop),
    .head  (in_head),
    .level (in_level),
    .full  (in_full),
    .empty (in_empty)
  );

  // Output side may write into a full FIFO when the host frees a slot in the same cycle.
  assign host_out_valid = ~out_empty;
  assign host_out_data  = out_head;
  assign out_pop        = host_out_valid & host_out_ready;
  assign out_push       = cpu_data_out_en & (~out_full | out_pop);

  bf_stream_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (out_push),
    .wdata (cpu_data_out),
    .pop   (out_pop),
    .head  (out_head),
    .level (out_level),
    .full  (out_full),
    .empty (out_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_overflow <= 1'b0;
    end else if (cpu_data_out_en && out_full && !out_pop) begin
      out_overflow <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^out_level;
endmodule

// File: tb/tb_bf_stream_io.sv
// Scoreboard bench for bf_stream_io: both input sources, both FIFO boundaries,
// output overflow and asynchronous reset.

module tb_bf_stream_io;
  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         gen_mode = 1'b0;
  logic [W-1:0] gen_seed = '0;
  logic [W-1:0] cpu_data_in;
  logic         cpu_data_available;
  logic         cpu_data_read = 1'b0;
  logic [W-1:0] cpu_data_out = '0;
  logic         cpu_data_out_en = 1'b0;
  logic [W-1:0] host_in_data = '0;
  logic         host_in_valid = 1'b0;
  logic         host_in_ready;
  logic [W-1:0] host_out_data;
  logic         host_out_valid;
  logic         host_out_ready = 1'b0;
  logic [4:0]   in_level;
  logic         out_overflow;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] in_q[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] exp_b;
  logic [W-1:0] gen_model;

  bf_stream_io #(.DATA_WIDTH(W), .DEPTH(D), .START_DELAY(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .gen_mode          (gen_mode),
    .gen_seed          (gen_seed),
    .cpu_data_in       (cpu_data_in),
    .cpu_data_available(cpu_data_available),
    .cpu_data_read     (cpu_data_read),
    .cpu_data_out      (cpu_data_out),
    .cpu_data_out_en   (cpu_data_out_en),
    .host_in_data      (host_in_data),
    .host_in_valid     (host_in_valid),
    .host_in_ready     (host_in_ready),
    .host_out_data     (host_out_data),
    .host_out_valid    (host_out_valid),
    .host_out_ready    (host_out_ready),
    .in_level          (in_level),
    .out_overflow      (out_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold_delay);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < hold_delay; i++) tick();
  endtask

  task automatic test_reset();
    gen_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    total_cnt++; if (cpu_data_available !== 1'b0) $display("FAIL rst_avail got %b expected 0", cpu_data_available); else pass_cnt++;
    total_cnt++; if (host_out_valid !== 1'b0) $display("FAIL rst_out_valid got %b expected 0", host_out_valid); else pass_cnt++;
    total_cnt++; if (host_in_ready !== 1'b1) $display("FAIL rst_in_ready got %b expected 1", host_in_ready); else pass_cnt++;
    total_cnt++; if (out_overflow !== 1'b0) $display("FAIL rst_overflow got %b expected 0", out_overflow); else pass_cnt++;
    total_cnt++; if (in_level !== 5'd0) $display("FAIL rst_in_level got %0d expected 0", in_level); else pass_cnt++;
    total_cnt++; if (cpu_data_in !== 8'h00) $display("FAIL rst_data_in got %h expected 00", cpu_data_in); else pass_cnt++;
    total_cnt++; if (host_out_data !== 8'h00) $display("FAIL rst_out_data got %h expected 00", host_out_data); else pass_cnt++;
  endtask

  task automatic test_generator();
    gen_seed = 8'hFE;
    gen_mode = 1'b1;
    cpu_data_read = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (cpu_data_available !== 1'b0) $display("FAIL gen_delay[%0d] avail got %b expected 0", i, cpu_data_available); else pass_cnt++;
      tick();
    end
    gen_model = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      out_q.push_back(gen_model);
      gen_model = gen_model + 8'd1;
    end
    for (int i = 0; i < 4; i++) begin
      exp_b = out_q.pop_front();
      total_cnt++; if (cpu_data_available !== 1'b1) $display("FAIL gen_avail[%0d] got %b expected 1", i, cpu_data_available); else pass_cnt++;
      total_cnt++; if (cpu_data_in !== exp_b) $display("FAIL gen_data[%0d] got %h expected %h", i, cpu_data_in, exp_b); else pass_cnt++;
      tick();
    end
    cpu_data_read = 1'b0;
    gen_mode = 1'b0;
  endtask

  task automatic fill_in(input logic [W-1:0] base);
    host_in_valid = 1'b1;
    for (int i = 0; i < D; i++) begin
      host_in_data = base + W'(i);
      in_q.push_back(host_in_data);
      tick();
    end
    host_in_valid = 1'b0;
  endtask

  task automatic drain_in(input string name);
    cpu_data_read = 1'b1;
    for (int i = 0; i < 2 * D && in_q.size() > 0; i++) begin
      exp_b = in_q.pop_front();
      total_cnt++; if (cpu_data_available !== 1'b1 || cpu_data_in !== exp_b)
        $display("FAIL %s[%0d] got avail=%b data=%h expected avail=1 data=%h", name, i, cpu_data_available, cpu_data_in, exp_b);
      else pass_cnt++;
      tick();
    end
    cpu_data_read = 1'b0;
  endtask

  task automatic test_fifo_fill_drain();
    gen_mode = 1'b0;
    fill_in(8'h10);
    total_cnt++; if (host_in_ready !== 1'b0) $display("FAIL full_ready got %b expected 0", host_in_ready); else pass_cnt++;
    total_cnt++; if (in_level !== 5'd16) $display("FAIL full_level got %0d expected 16", in_level); else pass_cnt++;
    drain_in("drain");
    total_cnt++; if (cpu_data_available !== 1'b0) $display("FAIL empty_avail got %b expected 0", cpu_data_available); else pass_cnt++;
    total_cnt++; if (in_level !== 5'd0) $display("FAIL empty_level got %0d expected 0", in_level); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    fill_in(8'h10);
    host_in_valid = 1'b1;
    host_in_data = 8'h20;
    cpu_data_read = 1'b1;
    exp_b = in_q.pop_front();
    total_cnt++; if (cpu_data_in !== exp_b) $display("FAIL fullpp_head got %h expected %h", cpu_data_in, exp_b); else pass_cnt++;
    tick();
    cpu_data_read = 1'b0;
    total_cnt++; if (in_level !== 5'd15) $display("FAIL fullpp_level got %0d expected 15", in_level); else pass_cnt++;
    total_cnt++; if (host_in_ready !== 1'b1) $display("FAIL fullpp_ready got %b expected 1", host_in_ready); else pass_cnt++;
    in_q.push_back(8'h20);
    tick();
    host_in_valid = 1'b0;
    total_cnt++; if (in_level !== 5'd16) $display("FAIL fullpp_refill got %0d expected 16", in_level); else pass_cnt++;
    drain_in("fullpp_drain");
  endtask

  task automatic test_empty_push_read();
    cpu_data_read = 1'b1;
    host_in_valid = 1'b1;
    host_in_data = 8'h42;
    total_cnt++; if (cpu_data_available !== 1'b0) $display("FAIL epr_avail0 got %b expected 0", cpu_data_available); else pass_cnt++;
    tick();
    cpu_data_read = 1'b0;
    host_in_valid = 1'b0;
    total_cnt++; if (cpu_data_available !== 1'b1 || cpu_data_in !== 8'h42)
      $display("FAIL epr_next got avail=%b data=%h expected avail=1 data=42", cpu_data_available, cpu_data_in);
    else pass_cnt++;
    total_cnt++; if (in_level !== 5'd1) $display("FAIL epr_level got %0d expected 1", in_level); else pass_cnt++;
    in_q.push_back(8'h42);
    drain_in("epr_drain");
  endtask

  task automatic test_mode_switch();
    host_in_valid = 1'b1;
    host_in_data = 8'h55;
    tick();
    host_in_valid = 1'b0;
    gen_mode = 1'b1;
    #1;
    total_cnt++; if (cpu_data_in !== gen_model) $display("FAIL sw_gen got %h expected %h", cpu_data_in, gen_model); else pass_cnt++;
    gen_mode = 1'b0;
    #1;
    total_cnt++; if (cpu_data_in !== 8'h55 || in_level !== 5'd1)
      $display("FAIL sw_fifo got data=%h level=%0d expected data=55 level=1", cpu_data_in, in_level);
    else pass_cnt++;
    in_q.push_back(8'h55);
    @(negedge clk);
    drain_in("sw_drain");
  endtask

  task automatic drain_out(input string name);
    host_out_ready = 1'b1;
    for (int i = 0; i < 2 * D && out_q.size() > 0; i++) begin
      exp_b = out_q.pop_front();
      total_cnt++; if (host_out_valid !== 1'b1 || host_out_data !== exp_b)
        $display("FAIL %s[%0d] got valid=%b data=%h expected valid=1 data=%h", name, i, host_out_valid, host_out_data, exp_b);
      else pass_cnt++;
      tick();
    end
    host_out_ready = 1'b0;
    total_cnt++; if (host_out_valid !== 1'b0) $display("FAIL %s_end valid got %b expected 0", name, host_out_valid); else pass_cnt++;
  endtask

  task automatic test_out_overflow();
    host_out_ready = 1'b0;
    cpu_data_out_en = 1'b1;
    for (int i = 0; i < D + 1; i++) begin
      cpu_data_out = W'(i);
      if (i < D) out_q.push_back(cpu_data_out);
      if (i == D) begin
        total_cnt++; if (out_overflow !== 1'b0) $display("FAIL ovf_before got %b expected 0", out_overflow); else pass_cnt++;
      end
      tick();
      if (i == 0) begin
        total_cnt++; if (host_out_valid !== 1'b1) $display("FAIL ovf_first_valid got %b expected 1", host_out_valid); else pass_cnt++;
      end
    end
    cpu_data_out_en = 1'b0;
    total_cnt++; if (out_overflow !== 1'b1) $display("FAIL ovf_set got %b expected 1", out_overflow); else pass_cnt++;
    drain_out("ovf_drain");
    total_cnt++; if (out_overflow !== 1'b1) $display("FAIL ovf_sticky got %b expected 1", out_overflow); else pass_cnt++;
  endtask

  task automatic test_out_full_pushpop_reset();
    do_reset(5);
    total_cnt++; if (out_overflow !== 1'b0) $display("FAIL opp_rst_ovf got %b expected 0", out_overflow); else pass_cnt++;
    cpu_data_out_en = 1'b1;
    for (int i = 0; i < D; i++) begin
      cpu_data_out = 8'h30 + W'(i);
      out_q.push_back(cpu_data_out);
      tick();
    end
    cpu_data_out = 8'hAA;
    host_out_ready = 1'b1;
    exp_b = out_q.pop_front();
    total_cnt++; if (host_out_data !== exp_b) $display("FAIL opp_head got %h expected %h", host_out_data, exp_b); else pass_cnt++;
    out_q.push_back(8'hAA);
    tick();
    cpu_data_out_en = 1'b0;
    host_out_ready = 1'b0;
    total_cnt++; if (out_overflow !== 1'b0) $display("FAIL opp_ovf got %b expected 0", out_overflow); else pass_cnt++;
    drain_out("opp_drain");

    cpu_data_out_en = 1'b1;
    for (int i = 0; i < D + 1; i++) begin
      cpu_data_out = W'(i);
      tick();
    end
    host_in_valid = 1'b1;
    host_in_data = 8'h77;
    for (int i = 0; i < 3; i++) tick();
    cpu_data_read = 1'b1;
    host_out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (in_level !== 5'd0) $display("FAIL mid_rst_level got %0d expected 0", in_level); else pass_cnt++;
    total_cnt++; if (host_out_valid !== 1'b0) $display("FAIL mid_rst_out_valid got %b expected 0", host_out_valid); else pass_cnt++;
    total_cnt++; if (out_overflow !== 1'b0) $display("FAIL mid_rst_ovf got %b expected 0", out_overflow); else pass_cnt++;
    total_cnt++; if (cpu_data_available !== 1'b0) $display("FAIL mid_rst_avail got %b expected 0", cpu_data_available); else pass_cnt++;
    total_cnt++; if (host_in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %b expected 1", host_in_ready); else pass_cnt++;
    cpu_data_out_en = 1'b0;
    host_in_valid = 1'b0;
    cpu_data_read = 1'b0;
    host_out_ready = 1'b0;
    out_q.delete();
    in_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_generator();
    test_fifo_fill_drain();
    test_full_push_pop();
    test_empty_push_read();
    test_mode_switch();
    test_out_overflow();
    test_out_full_pushpop_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
